// File: rtl/wb_stage.sv
// Write-back stage: accepts completed instructions from the memory stage, holds
// each for one cycle and drives the register-file write port plus a forwarding
// path. Optional retired-instruction counter enabled by `WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               halt_i,
  input  logic               valid_i,
  output logic               ack_o,
  input  logic [31:0]        instr_i,
  input  logic [BITSIZE-1:0] data_i,
  output logic               rf_we_o,
  output logic [4:0]         rf_waddr_o,
  output logic [BITSIZE-1:0] rf_wdata_o,
  output logic               fwd_valid_o,
  output logic [4:0]         fwd_rd_o,
  output logic [BITSIZE-1:0] fwd_data_o,
  output logic               illegal_o,
  output logic [63:0]        retired_o
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic               illegal;
    logic [4:0]         rd;
    logic [BITSIZE-1:0] data;
  } wb_entry_t;

  wb_entry_t  wb_q;
  logic       accept;
  logic       writes_rd;
  logic       dec_illegal;
  logic [4:0] dec_rd;
  logic       unused_instr;

  assign dec_rd       = instr_i[11:7];
  assign unused_instr = ^instr_i[31:12];

  // Gating with reset keeps ack low while the stage is held in reset even if
  // upstream is still presenting an instruction.
  assign accept = valid_i & ~halt_i & rstn_i;
  assign ack_o  = accept;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    writes_rd   = 1'b0;
    dec_illegal = 1'b0;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP,
      OPC_LUI, OPC_JALR, OPC_JAL:           writes_rd   = 1'b1;
      OPC_STORE, OPC_BRANCH,
      OPC_MISC_MEM, OPC_SYSTEM:             writes_rd   = 1'b0;
      default:                              dec_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_q <= '0;
    end else if (!halt_i) begin
      if (valid_i) begin
        wb_q.valid   <= 1'b1;
        wb_q.we      <= writes_rd & (dec_rd != 5'd0);
        wb_q.illegal <= dec_illegal;
        wb_q.rd      <= dec_rd;
        wb_q.data    <= data_i;
      end else begin
        wb_q.valid <= 1'b0;
      end
    end
  end

  // Forwarding ignores halt so a stalled consumer still sees the pending value;
  // the write strobe is gated so a held entry is written exactly once.
  assign fwd_valid_o = wb_q.valid & wb_q.we;
  assign fwd_rd_o    = wb_q.rd;
  assign fwd_data_o  = wb_q.data;
  assign rf_we_o     = fwd_valid_o & ~halt_i;
  assign rf_waddr_o  = wb_q.rd;
  assign rf_wdata_o  = wb_q.data;
  assign illegal_o   = wb_q.valid & wb_q.illegal;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      retired_q <= '0;
    end else if (accept) begin
      retired_q <= retired_q + 64'd1;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed table-driven bench for wb_stage, plus hand-written reset, counter
// wrap and halt corner sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        halt_i;
  logic        valid_i;
  logic        ack_o;
  logic [31:0] instr_i;
  logic [31:0] data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic        illegal_o;
  logic [63:0] retired_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] ret_model = '0;

  always #5 clk = ~clk;

  wb_stage #(.BITSIZE(32)) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .halt_i     (halt_i),
    .valid_i    (valid_i),
    .ack_o      (ack_o),
    .instr_i    (instr_i),
    .data_i     (data_i),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .fwd_valid_o(fwd_valid_o),
    .fwd_rd_o   (fwd_rd_o),
    .fwd_data_o (fwd_data_o),
    .illegal_o  (illegal_o),
    .retired_o  (retired_o)
  );

  // Inputs applied this cycle, and the outputs expected during the same cycle.
  typedef struct {
    logic        halt;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] data;
    logic        ack;
    logic        rf_we;
    logic        fwd;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] exp_retired(input logic [63:0] cnt);
`ifdef WB_RETIRE_CNT_EN
    return cnt;
`else
    return 64'd0 & cnt;
`endif
  endfunction

  task automatic drive(input logic h, input logic v, input logic [31:0] ins, input logic [31:0] d);
    halt_i  = h;
    valid_i = v;
    instr_i = ins;
    data_i  = d;
  endtask

  initial begin
    // halt valid instr data | ack we fwd ill rd wdata
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});        // idle
    vecs.push_back('{0, 1, 32'h00A0_0293, 32'h0000_000A, 1, 0, 0, 0, 5'd0,  32'h0});       // ADDI x5
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 1, 1, 0, 5'd5,  32'h0000_000A});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 1, 32'h0062_A023, 32'h0000_0011, 1, 0, 0, 0, 5'd0,  32'h0});       // SW
    vecs.push_back('{0, 1, 32'h0020_8463, 32'h0000_0022, 1, 0, 0, 0, 5'd0,  32'h0});       // BEQ
    vecs.push_back('{0, 1, 32'h0010_0013, 32'h0000_0033, 1, 0, 0, 0, 5'd0,  32'h0});       // ADDI x0
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 1, 32'h0000_01FF, 32'h0000_0044, 1, 0, 0, 0, 5'd0,  32'h0});       // opcode 0x7F rd=3
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 1, 5'd0,  32'h0});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 1, 32'h1234_5537, 32'h1234_5000, 1, 0, 0, 0, 5'd0,  32'h0});       // LUI x10
    vecs.push_back('{0, 1, 32'h0000_00EF, 32'h0000_0104, 1, 1, 1, 0, 5'd10, 32'h1234_5000}); // JAL x1
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 1, 1, 0, 5'd1,  32'h0000_0104});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 1, 32'h0002_A383, 32'hDEAD_BEEF, 1, 0, 0, 0, 5'd0,  32'h0});       // LW x7
    vecs.push_back('{1, 1, 32'h00A0_0293, 32'h0000_0055, 0, 0, 1, 0, 5'd7,  32'hDEAD_BEEF}); // halted
    vecs.push_back('{1, 0, 32'h0000_0000, 32'h0,        0, 0, 1, 0, 5'd7,  32'hDEAD_BEEF});
    vecs.push_back('{1, 1, 32'h00A0_0293, 32'h0000_0055, 0, 0, 1, 0, 5'd7,  32'hDEAD_BEEF});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 1, 1, 0, 5'd7,  32'hDEAD_BEEF});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 1, 32'h0000_0117, 32'h0000_0200, 1, 0, 0, 0, 5'd0,  32'h0});       // AUIPC x2
    vecs.push_back('{0, 1, 32'h0020_81B3, 32'h0000_0007, 1, 1, 1, 0, 5'd2,  32'h0000_0200}); // ADD x3
    vecs.push_back('{0, 1, 32'h0000_8267, 32'h0000_0300, 1, 1, 1, 0, 5'd3,  32'h0000_0007}); // JALR x4
    vecs.push_back('{0, 1, 32'h0000_028F, 32'h0000_0009, 1, 1, 1, 0, 5'd4,  32'h0000_0300}); // MISC-MEM rd=5
    vecs.push_back('{0, 1, 32'h0000_0373, 32'h0000_0001, 1, 0, 0, 0, 5'd0,  32'h0});       // SYSTEM rd=6
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 0, 5'd0,  32'h0});

    // Reset state
    rstn_i = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack",     {63'd0, ack_o},       64'd0);
    check("reset_rf_we",   {63'd0, rf_we_o},     64'd0);
    check("reset_fwd",     {63'd0, fwd_valid_o}, 64'd0);
    check("reset_illegal", {63'd0, illegal_o},   64'd0);
    check("reset_retired", retired_o,            64'd0);
    @(negedge clk);
    rstn_i = 1'b1;

    // Table: outputs checked mid-cycle after inputs settle, then clocked
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].halt, vecs[i].valid, vecs[i].instr, vecs[i].data);
      #1;
      check($sformatf("v%0d_ack", i),     {63'd0, ack_o},       {63'd0, vecs[i].ack});
      check($sformatf("v%0d_rf_we", i),   {63'd0, rf_we_o},     {63'd0, vecs[i].rf_we});
      check($sformatf("v%0d_fwd", i),     {63'd0, fwd_valid_o}, {63'd0, vecs[i].fwd});
      check($sformatf("v%0d_illegal", i), {63'd0, illegal_o},   {63'd0, vecs[i].ill});
      check($sformatf("v%0d_retired", i), retired_o,            exp_retired(ret_model));
      if (vecs[i].rf_we || vecs[i].fwd) begin
        check($sformatf("v%0d_waddr", i),  {59'd0, rf_waddr_o}, {59'd0, vecs[i].rd});
        check($sformatf("v%0d_wdata", i),  {32'd0, rf_wdata_o}, {32'd0, vecs[i].wdata});
        check($sformatf("v%0d_fwd_rd", i), {59'd0, fwd_rd_o},   {59'd0, vecs[i].rd});
        check($sformatf("v%0d_fwd_dat", i), {32'd0, fwd_data_o}, {32'd0, vecs[i].wdata});
      end
      if (vecs[i].ack) ret_model = ret_model + 64'd1;
    end
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    #1;
    check("table_retired_total", retired_o, exp_retired(64'd13));

    // Reset mid-stream with an entry held: discard, no write after release
    @(negedge clk);
    drive(0, 1, 32'h0000_0493, 32'h0000_0099);        // ADDI x9
    @(posedge clk);
    #1;
    check("pre_rst_fwd", {63'd0, fwd_valid_o}, 64'd1);
    #1;
    rstn_i = 1'b0;
    #1;
    check("mid_rst_ack",   {63'd0, ack_o},       64'd0);
    check("mid_rst_rf_we", {63'd0, rf_we_o},     64'd0);
    check("mid_rst_fwd",   {63'd0, fwd_valid_o}, 64'd0);
    check("mid_rst_waddr", {59'd0, rf_waddr_o},  64'd0);
    check("mid_rst_wdata", {32'd0, rf_wdata_o},  64'd0);
    check("mid_rst_ret",   retired_o,            64'd0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    rstn_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("post_rst_rf_we%0d", c), {63'd0, rf_we_o}, 64'd0);
      check($sformatf("post_rst_ret%0d", c),   retired_o,        64'd0);
      @(negedge clk);
    end

    // Halt on an empty stage with valid high must not accept anything
    drive(1, 1, 32'h00A0_0293, 32'h0000_0077);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
    #1;
    check("halt_empty_fwd",   {63'd0, fwd_valid_o}, 64'd0);
    check("halt_empty_rf_we", {63'd0, rf_we_o},     64'd0);

`ifdef WB_RETIRE_CNT_EN
    // Counter wrap from all-ones
    @(negedge clk);
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    drive(0, 1, 32'h0062_A023, 32'h0);
    @(posedge clk);
    #1;
    check("wrap_retired", retired_o, 64'd0);
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
